// File: rtl/falafel_lsu_arbiter.sv
// Round-robin arbiter that lets N_REQ allocator engines share one LSU port.
// It keeps one transaction outstanding at a time. While a requester holds the
// free-list lock, only that requester can be granted.

package falafel_pkg;
    typedef enum logic [31:0] {
        LSU_LOCK   = 32'd0,
        LSU_UNLOCK = 32'd1,
        LSU_LOAD   = 32'd2,
        LSU_UPDATE = 32'd3,
        LSU_INSERT = 32'd4,
        LSU_DELETE = 32'd5
    } lsu_op_e;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
        lsu_op_e     lsu_op;
        logic        val;
    } header_data_req_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
        logic        val;
    } header_data_rsp_t;
endpackage

// state    | meaning
// S_IDLE   | no transaction outstanding; grant the next eligible requester
// S_ISSUE  | lsu_req_o valid and held until the LSU accepts it
// S_WAIT   | request accepted by the LSU; waiting for its response
module falafel_lsu_arbiter
    import falafel_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  header_data_req_t req_i [N_REQ],
    output logic [N_REQ-1:0] req_rdy_o,
    output header_data_rsp_t rsp_o [N_REQ],
    output header_data_req_t lsu_req_o,
    input  logic             lsu_req_rdy_i,
    input  header_data_rsp_t lsu_rsp_i,
    output logic             locked_o,
    output logic [IDX_W-1:0] lock_owner_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic             locked_q, locked_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    lsu_op_e          op_q, op_d;
    header_data_req_t lsu_req_q, lsu_req_d;
    header_data_rsp_t rsp_q, rsp_d;

    logic [N_REQ-1:0] elig;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [N_REQ-1:0] req_rdy_c;

    // Eligibility mask and round-robin pick that starts scanning at rr_ptr.
    always_comb begin
        elig       = '0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            elig[k] = req_i[k].val && (!locked_q || (owner_q == IDX_W'(k)));
        end
        for (int i = 0; i < N_REQ; i++) begin
            automatic int c = int'(rr_ptr_q) + i;
            if (c >= N_REQ) c = c - N_REQ;
            if (!pick_found && elig[c]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(c);
            end
        end
    end

    // Next-state logic: grant, issue to the LSU, collect the response, update the lock.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        locked_d  = locked_q;
        owner_d   = owner_q;
        op_d      = op_q;
        lsu_req_d = lsu_req_q;
        rsp_d     = '0;
        req_rdy_c = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    req_rdy_c     = N_REQ'(1) << pick_idx;
                    lsu_req_d     = req_i[pick_idx];
                    lsu_req_d.val = 1'b1;
                    grant_d       = pick_idx;
                    op_d          = req_i[pick_idx].lsu_op;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (lsu_req_rdy_i) begin
                    lsu_req_d = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lsu_rsp_i.val) begin
                    rsp_d     = lsu_rsp_i;
                    rsp_d.val = 1'b1;
                    if (op_q == LSU_LOCK) begin
                        locked_d = 1'b1;
                        owner_d  = grant_q;
                    end else if (op_q == LSU_UNLOCK) begin
                        locked_d = 1'b0;
                    end
                    rr_ptr_d = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                lsu_req_d = '0;
            end
        endcase
    end

    // State and datapath registers. Reset aborts any transaction and drops the lock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            owner_q   <= '0;
            op_q      <= LSU_LOCK;
            lsu_req_q <= '0;
            rsp_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            lsu_req_q <= lsu_req_d;
            rsp_q     <= rsp_d;
        end
    end

    // Steer the registered response to the granted requester only. rsp_q is zero when not valid.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            rsp_o[k] = (grant_q == IDX_W'(k)) ? rsp_q : '0;
        end
    end

    // The accept pulse is combinational, so gate it with reset to keep it low while reset is asserted.
    always_comb begin
        req_rdy_o    = rst_i ? '0 : req_rdy_c;
        lsu_req_o    = lsu_req_q;
        locked_o     = locked_q;
        lock_owner_o = owner_q;
    end

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Directed testbench for falafel_lsu_arbiter with N_REQ=2.
module tb_falafel_lsu_arbiter;
    import falafel_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    header_data_req_t req [2];
    logic [1:0]       rdy;
    header_data_rsp_t rsp [2];
    header_data_req_t lsu_req;
    logic             lsu_rdy;
    header_data_rsp_t lsu_rsp;
    logic             locked;
    logic [0:0]       owner;

    int checks = 0;
    int errors = 0;

    falafel_lsu_arbiter #(.N_REQ(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_rdy_o    (rdy),
        .rsp_o        (rsp),
        .lsu_req_o    (lsu_req),
        .lsu_req_rdy_i(lsu_rdy),
        .lsu_rsp_i    (lsu_rsp),
        .locked_o     (locked),
        .lock_owner_o (owner)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        req[0]  = '0;
        req[1]  = '0;
        lsu_rsp = '0;
        lsu_rdy = 1'b1;
    endtask

    task automatic set_req(input int idx, input lsu_op_e op, input logic [63:0] addr,
                           input logic [63:0] size, input logic v);
        req[idx].addr      = addr;
        req[idx].size      = size;
        req[idx].next_addr = 64'h0;
        req[idx].lsu_op    = op;
        req[idx].val       = v;
    endtask

    task automatic drive_rsp(input logic [63:0] addr, input logic [63:0] size,
                             input logic [63:0] nxt);
        lsu_rsp.addr      = addr;
        lsu_rsp.size      = size;
        lsu_rsp.next_addr = nxt;
        lsu_rsp.val       = 1'b1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One complete transaction for requester idx; returns in the IDLE cycle that carries the response.
    task automatic run_txn(input int idx, input lsu_op_e op, input logic [63:0] addr,
                           input logic [63:0] size);
        bit got;
        @(negedge clk);
        set_req(idx, op, addr, size, 1'b1);
        #1;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (rdy[idx]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL txn_accept idx=%0d rdy=%b required bit %0d set", idx, rdy, idx);
        end
        @(negedge clk);
        req[idx].val = 1'b0;
        @(negedge clk);
        drive_rsp(addr, size, addr + 64'h100);
        @(negedge clk);
        lsu_rsp = '0;
        #1;
        checks++;
        if (rsp[idx].val !== 1'b1 || rsp[idx].size !== size) begin
            errors++;
            $display("FAIL txn_rsp idx=%0d val=%b size=%h required val=1 size=%h",
                     idx, rsp[idx].val, rsp[idx].size, size);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        set_req(0, LSU_LOAD, 64'h55, 64'h0, 1'b1);
        drive_rsp(64'h1, 64'h2, 64'h3);
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rdy !== 2'b00 || lsu_req !== '0 || rsp[0] !== '0 || rsp[1] !== '0 ||
            locked !== 1'b0 || owner !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%b lsu_val=%b rsp0_val=%b rsp1_val=%b locked=%b owner=%b required all 0",
                     rdy, lsu_req.val, rsp[0].val, rsp[1].val, locked, owner);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_load();
        apply_reset();
        @(negedge clk);
        set_req(0, LSU_LOAD, 64'h1000, 64'h0, 1'b1);
        #1;
        checks++;
        if (rdy !== 2'b01) begin
            errors++;
            $display("FAIL single_accept rdy=%b required 01", rdy);
        end
        @(negedge clk);
        req[0].val = 1'b0;
        #1;
        checks++;
        if (rdy !== 2'b00 || lsu_req.val !== 1'b1 || lsu_req.addr !== 64'h1000 ||
            lsu_req.lsu_op !== LSU_LOAD) begin
            errors++;
            $display("FAIL single_issue rdy=%b val=%b addr=%h op=%0d required 00 1 1000 %0d",
                     rdy, lsu_req.val, lsu_req.addr, lsu_req.lsu_op, LSU_LOAD);
        end
        @(negedge clk);
        drive_rsp(64'h1000, 64'h40, 64'h2000);
        #1;
        checks++;
        if (lsu_req.val !== 1'b0 || lsu_req.addr !== 64'h0) begin
            errors++;
            $display("FAIL single_lsu_clear val=%b addr=%h required 0 0", lsu_req.val, lsu_req.addr);
        end
        @(negedge clk);
        lsu_rsp = '0;
        #1;
        checks++;
        if (rsp[0].val !== 1'b1 || rsp[0].size !== 64'h40 || rsp[0].next_addr !== 64'h2000 ||
            rsp[0].addr !== 64'h1000 || rsp[1].val !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp val0=%b size=%h next=%h addr=%h val1=%b required 1 40 2000 1000 0",
                     rsp[0].val, rsp[0].size, rsp[0].next_addr, rsp[0].addr, rsp[1].val);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp[0] !== '0 || rsp[1] !== '0 || rdy !== 2'b00) begin
            errors++;
            $display("FAIL single_rsp_pulse val0=%b size=%h rdy=%b required 0 0 00",
                     rsp[0].val, rsp[0].size, rdy);
        end
    endtask

    task automatic test_fairness();
        int exp_idx;
        int prev_idx;
        apply_reset();
        @(negedge clk);
        set_req(0, LSU_LOAD, 64'h100, 64'h0, 1'b1);
        set_req(1, LSU_LOAD, 64'h200, 64'h0, 1'b1);
        prev_idx = 0;
        for (int t = 0; t < 4; t++) begin
            exp_idx = t % 2;
            #1;
            checks++;
            if (rdy !== (2'b01 << exp_idx)) begin
                errors++;
                $display("FAIL fair_grant t=%0d rdy=%b required idx %0d", t, rdy, exp_idx);
            end
            if (t > 0) begin
                checks++;
                if (rsp[prev_idx].val !== 1'b1 || rsp[exp_idx].val !== 1'b0) begin
                    errors++;
                    $display("FAIL fair_rsp t=%0d rsp_prev=%b rsp_cur=%b required 1 0",
                             t, rsp[prev_idx].val, rsp[exp_idx].val);
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (lsu_req.addr !== ((exp_idx == 1) ? 64'h200 : 64'h100)) begin
                errors++;
                $display("FAIL fair_issue t=%0d addr=%h required %h", t, lsu_req.addr,
                         (exp_idx == 1) ? 64'h200 : 64'h100);
            end
            @(negedge clk);
            drive_rsp(64'h0, 64'h8, 64'h0);
            @(negedge clk);
            lsu_rsp = '0;
            if (t == 3) begin
                req[0].val = 1'b0;
                req[1].val = 1'b0;
            end
            prev_idx = exp_idx;
        end
        #1;
        checks++;
        if (rsp[1].val !== 1'b1 || rsp[0].val !== 1'b0 || rdy !== 2'b00) begin
            errors++;
            $display("FAIL fair_last rsp1=%b rsp0=%b rdy=%b required 1 0 00", rsp[1].val, rsp[0].val, rdy);
        end
    endtask

    task automatic test_lock_exclusion();
        lsu_op_e ops [3];
        ops[0] = LSU_LOAD;
        ops[1] = LSU_UPDATE;
        ops[2] = LSU_UNLOCK;
        apply_reset();
        @(negedge clk);
        set_req(1, LSU_LOCK, 64'h500, 64'h0, 1'b1);
        #1;
        checks++;
        if (rdy !== 2'b10) begin
            errors++;
            $display("FAIL lock_grant rdy=%b required 10", rdy);
        end
        @(negedge clk);
        set_req(1, LSU_LOAD, 64'h510, 64'h0, 1'b1);
        set_req(0, LSU_LOAD, 64'h600, 64'h0, 1'b1);
        @(negedge clk);
        drive_rsp(64'h500, 64'h0, 64'h0);
        #1;
        checks++;
        if (rdy !== 2'b00 || locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_pending rdy=%b locked=%b required 00 0", rdy, locked);
        end
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            lsu_rsp = '0;
            #1;
            checks++;
            if (locked !== 1'b1 || owner !== 1'b1 || rdy !== 2'b10) begin
                errors++;
                $display("FAIL lock_held j=%0d locked=%b owner=%b rdy=%b required 1 1 10", j, locked, owner, rdy);
            end
            if (j == 0) begin
                checks++;
                if (rsp[1].val !== 1'b1 || rsp[0].val !== 1'b0) begin
                    errors++;
                    $display("FAIL lock_rsp rsp1=%b rsp0=%b required 1 0", rsp[1].val, rsp[0].val);
                end
            end
            @(negedge clk);
            if (j < 2) set_req(1, ops[j+1], 64'h520, 64'h20, 1'b1);
            else       req[1].val = 1'b0;
            #1;
            checks++;
            if (rdy !== 2'b00) begin
                errors++;
                $display("FAIL lock_excl_issue j=%0d rdy=%b required 00", j, rdy);
            end
            if (j == 1) begin
                checks++;
                if (lsu_req.size !== 64'h20 || lsu_req.lsu_op !== LSU_UPDATE) begin
                    errors++;
                    $display("FAIL lock_update size=%h op=%0d required 20 %0d", lsu_req.size, lsu_req.lsu_op, LSU_UPDATE);
                end
            end
            @(negedge clk);
            drive_rsp(64'h520, 64'h20, 64'h0);
            #1;
            checks++;
            if (rdy !== 2'b00) begin
                errors++;
                $display("FAIL lock_excl_wait j=%0d rdy=%b required 00", j, rdy);
            end
        end
        @(negedge clk);
        lsu_rsp = '0;
        #1;
        checks++;
        if (locked !== 1'b0 || rdy !== 2'b01) begin
            errors++;
            $display("FAIL unlock_release locked=%b rdy=%b required 0 01", locked, rdy);
        end
        @(negedge clk);
        req[0].val = 1'b0;
        @(negedge clk);
        drive_rsp(64'h600, 64'h0, 64'h0);
        @(negedge clk);
        lsu_rsp = '0;
        #1;
        checks++;
        if (rsp[0].val !== 1'b1 || rsp[1].val !== 1'b0) begin
            errors++;
            $display("FAIL unlock_req0_rsp rsp0=%b rsp1=%b required 1 0", rsp[0].val, rsp[1].val);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        lsu_rdy = 1'b0;
        @(negedge clk);
        set_req(0, LSU_LOAD, 64'h3000, 64'h0, 1'b1);
        set_req(1, LSU_LOAD, 64'h4000, 64'h0, 1'b1);
        #1;
        checks++;
        if (rdy !== 2'b01) begin
            errors++;
            $display("FAIL bp_accept rdy=%b required 01", rdy);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (lsu_req.val !== 1'b1 || lsu_req.addr !== 64'h3000 || rdy !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold c=%0d val=%b addr=%h rdy=%b required 1 3000 00", c, lsu_req.val, lsu_req.addr, rdy);
            end
        end
        @(negedge clk);
        lsu_rdy = 1'b1;
        #1;
        checks++;
        if (lsu_req.val !== 1'b1 || rdy !== 2'b00) begin
            errors++;
            $display("FAIL bp_release val=%b rdy=%b required 1 00", lsu_req.val, rdy);
        end
        @(negedge clk);
        drive_rsp(64'h3000, 64'h10, 64'h0);
        #1;
        checks++;
        if (lsu_req.val !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepted val=%b required 0", lsu_req.val);
        end
        @(negedge clk);
        lsu_rsp = '0;
        req[0].val = 1'b0;
        req[1].val = 1'b0;
        #1;
        checks++;
        if (rsp[0].val !== 1'b1 || rsp[0].size !== 64'h10) begin
            errors++;
            $display("FAIL bp_rsp val=%b size=%h required 1 10", rsp[0].val, rsp[0].size);
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        run_txn(1, LSU_LOCK, 64'h700, 64'h0);
        checks++;
        if (locked !== 1'b1 || owner !== 1'b1) begin
            errors++;
            $display("FAIL rmid_locked locked=%b owner=%b required 1 1", locked, owner);
        end
        @(negedge clk);
        set_req(1, LSU_LOAD, 64'h710, 64'h0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (locked !== 1'b0 || owner !== 1'b0 || lsu_req !== '0 || rdy !== 2'b00 ||
            rsp[0] !== '0 || rsp[1] !== '0) begin
            errors++;
            $display("FAIL rmid_async locked=%b owner=%b lsu_val=%b rdy=%b rsp0=%b rsp1=%b required all 0",
                     locked, owner, lsu_req.val, rdy, rsp[0].val, rsp[1].val);
        end
        @(negedge clk);
        req[1].val = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        drive_rsp(64'h710, 64'h1, 64'h2);
        @(negedge clk);
        lsu_rsp = '0;
        #1;
        checks++;
        if (rsp[0].val !== 1'b0 || rsp[1].val !== 1'b0 || locked !== 1'b0 || lsu_req.val !== 1'b0) begin
            errors++;
            $display("FAIL rmid_late_rsp rsp0=%b rsp1=%b locked=%b lsu_val=%b required 0 0 0 0",
                     rsp[0].val, rsp[1].val, locked, lsu_req.val);
        end
    endtask

    task automatic test_spurious();
        apply_reset();
        run_txn(0, LSU_LOAD, 64'h800, 64'h8);
        @(negedge clk);
        drive_rsp(64'hdead, 64'hbeef, 64'h1);
        @(negedge clk);
        lsu_rsp = '0;
        set_req(0, LSU_LOAD, 64'h810, 64'h0, 1'b1);
        set_req(1, LSU_LOAD, 64'h820, 64'h0, 1'b1);
        #1;
        checks++;
        if (rsp[0].val !== 1'b0 || rsp[1].val !== 1'b0 || locked !== 1'b0 || rdy !== 2'b10) begin
            errors++;
            $display("FAIL spurious rsp0=%b rsp1=%b locked=%b rdy=%b required 0 0 0 10",
                     rsp[0].val, rsp[1].val, locked, rdy);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_lock_corner();
        apply_reset();
        run_txn(0, LSU_UNLOCK, 64'h900, 64'h0);
        checks++;
        if (locked !== 1'b0) begin
            errors++;
            $display("FAIL unlock_when_unlocked locked=%b required 0", locked);
        end
        run_txn(0, LSU_LOCK, 64'h910, 64'h0);
        run_txn(0, LSU_LOCK, 64'h920, 64'h0);
        checks++;
        if (locked !== 1'b1 || owner !== 1'b0) begin
            errors++;
            $display("FAIL relock_owner locked=%b owner=%b required 1 0", locked, owner);
        end
        run_txn(0, LSU_INSERT, 64'h930, 64'h4);
        checks++;
        if (locked !== 1'b1 || owner !== 1'b0) begin
            errors++;
            $display("FAIL insert_keeps_lock locked=%b owner=%b required 1 0", locked, owner);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_load();
        test_fairness();
        test_lock_exclusion();
        test_backpressure();
        test_reset_mid_op();
        test_spurious();
        test_lock_corner();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/falafel_lsu_arbiter.md
Name: falafel_lsu_arbiter

Overview:
Shares the single allocator LSU port among N_REQ allocator request engines, one transaction at a time. Arbitration is round-robin. The arbiter tracks LOCK/UNLOCK so that while a requester holds the free-list lock, only that requester is served. It sits between the allocator cores and the LSU, using the falafel_pkg header_data_req_t and header_data_rsp_t structs unchanged.

Parameters:
N_REQ, 2, number of requesters (>=2)
IDX_W, $clog2(N_REQ), width of requester index (derived localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
req_i  in  N_REQ x header_data_req_t  per-requester request; .val is request-valid
req_rdy_o  out  N_REQ  one-hot accept pulse; request consumed when req_i[k].val && req_rdy_o[k]
rsp_o  out  N_REQ x header_data_rsp_t  per-requester response; .val is a one-cycle pulse
lsu_req_o  out  header_data_req_t  request to LSU; .val is valid
lsu_req_rdy_i  in  1  LSU accepts lsu_req_o when lsu_req_o.val && lsu_req_rdy_i
lsu_rsp_i  in  header_data_rsp_t  LSU response; .val is a one-cycle pulse
locked_o  out  1  lock currently held
lock_owner_o  out  IDX_W  lock holder index; valid when locked_o=1

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, grant=0, locked_o=0, lock_owner_o=0. All req_rdy_o=0. All rsp_o fields=0. lsu_req_o all fields=0 (lsu_op=LOCK encoding 0).
- Eligibility: when locked_o=0, every k with req_i[k].val is eligible. When locked_o=1, only k==lock_owner_o is eligible; all others see req_rdy_o=0 whatever op they present.
- FSM, single outstanding transaction:
  - IDLE: if any eligible, pick g = first eligible index scanning rr_ptr, rr_ptr+1, ... mod N_REQ. Assert req_rdy_o[g]=1 this cycle (combinational, only in IDLE). Register req_i[g] into lsu_req_o with .val=1. Register grant=g. Next state ISSUE.
  - ISSUE: lsu_req_o held stable. When lsu_req_rdy_i=1, clear lsu_req_o.val next cycle and go to WAIT_RSP.
  - WAIT_RSP: on lsu_rsp_i.val=1, register lsu_rsp_i into rsp_o[grant] with .val=1 for exactly one cycle. Update the lock. Set rr_ptr = (grant+1) mod N_REQ. Go to IDLE.
- Lock update, applied on the response of the granted op only:
  - LOCK: locked_o<=1, lock_owner_o<=grant. A repeated LOCK by the owner is forwarded and leaves the owner unchanged.
  - UNLOCK: locked_o<=0. An UNLOCK while unlocked is forwarded; locked_o stays 0.
  - LOAD, UPDATE, INSERT, DELETE: no lock change.
- Timing, best case: accept at T, lsu_req_o.val visible T+1, LSU accept T+1, LSU response T+2, rsp_o[g].val T+3, next accept T+3 (the IDLE cycle). Throughput is at most one transaction per 3 cycles.
- rsp_o[k] for k!=grant: all fields 0. rsp_o data is zeroed when .val deasserts.
- lsu_rsp_i.val in IDLE or ISSUE: ignored, with no state change. The LSU must not respond before accept.
- The lock is not released by reset of a requester, only by UNLOCK or rst_i.
- rst_i mid-transaction: abort immediately and clear the lock. A late lsu_rsp_i after release is ignored (state is IDLE).
- Bit widths: header fields pass through unmodified (64-bit addr/size/next_addr; lsu_op 32-bit enum).

Test Plan:
- Single LOAD: req_i[0]={addr=0x1000,op=LOAD,val=1}, lsu_req_rdy_i=1, LSU responds next cycle {addr=0x1000,size=0x40,next=0x2000} -> exactly one req_rdy_o[0] pulse; lsu_req_o.addr=0x1000 for one cycle; rsp_o[0].val one cycle carrying size=0x40 next=0x2000; rsp_o[1].val stays 0.
- Fairness: both requesters hold val=1 continuously with LOAD from reset -> service order 0,1,0,1; each rsp_o pulse goes to the matching index.
- Lock exclusion: req1 LOCK granted -> locked_o=1, lock_owner_o=1. req0 LOAD held valid meanwhile sees req_rdy_o[0]=0 while req1 LOAD, UPDATE(size=0x20), UNLOCK are served. After the UNLOCK response, locked_o=0 and req0 is accepted at the next IDLE cycle.
- LSU backpressure: lsu_req_rdy_i=0 for 5 cycles after accept -> lsu_req_o stable and .val=1 throughout; no req_rdy_o pulse to any requester; transaction completes after rdy rises.
- Reset mid-op: assert rst_i in WAIT_RSP with locked_o=1 -> all outputs 0 asynchronously; after release, an lsu_rsp_i.val pulse yields no rsp_o pulse.
- Spurious response: lsu_rsp_i.val=1 in IDLE with no requests -> all rsp_o.val stay 0; rr_ptr and lock unchanged.
